// File: rtl/mon_queue_ctrl_pkg.sv
// Shared types for the monitoring queue controller: default record size,
// the record container type and the controller state encoding.
package DMNIPkg;

  localparam int MON_ENTRY_WORDS_DEF = 4;

  // One monitoring record: MON_ENTRY_WORDS_DEF 32-bit words, word 0 in the low slice.
  typedef logic [MON_ENTRY_WORDS_DEF-1:0][31:0] mon_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2
  } mon_queue_state_t;

endpackage

// File: rtl/mon_queue_ctrl.sv
// Monitoring queue controller: accepts fixed-size records and writes them
// word by word into a ring buffer in memory. A free-slot semaphore (sem_av)
// gates acceptance, an occupied-slot semaphore (sem_oc) is published to software.
module mon_queue_ctrl
  import DMNIPkg::*;
#(
  parameter int MON_ENTRY_WORDS = MON_ENTRY_WORDS_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             mon_reset_i,
  input  logic [31:0]                      mon_addr_i,
  input  logic [7:0]                       mon_size_i,
  input  logic [7:0]                       mon_sem_av_i,
  input  logic                             mon_sem_av_post_i,
  input  logic                             mon_sem_oc_wait_i,
  output logic [7:0]                       mon_sem_oc_o,
  output logic                             mon_active_o,
  input  logic                             evt_valid_i,
  output logic                             evt_ready_o,
  input  logic [MON_ENTRY_WORDS-1:0][31:0] evt_data_i,
  output logic                             mem_req_o,
  input  logic                             mem_gnt_i,
  output logic [31:0]                      mem_addr_o,
  output logic [31:0]                      mem_data_o,
  output logic [3:0]                       mem_we_o
);

  localparam int IDX_W = (MON_ENTRY_WORDS > 1) ? $clog2(MON_ENTRY_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MON_ENTRY_WORDS - 1);

  mon_queue_state_t                  state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [7:0]                        head_q, head_d;
  logic [7:0]                        sem_av_q, sem_av_d;
  logic [7:0]                        sem_oc_q, sem_oc_d;
  logic [MON_ENTRY_WORDS-1:0][31:0]  entry_q;
  logic                              accept;
  logic                              commit;
  logic [31:0]                       word_off;

  assign evt_ready_o  = (state_q == IDLE) && (sem_av_q != 8'd0) &&
                        (mon_size_i != 8'd0) && !mon_reset_i;
  assign accept       = evt_valid_i && evt_ready_o;
  assign commit       = (state_q == COMMIT);
  assign mon_active_o = (state_q != IDLE);
  assign mon_sem_oc_o = sem_oc_q;

  // Slot offset in words; 32-bit arithmetic wraps on overflow by design.
  assign word_off = (32'(head_q) * 32'(MON_ENTRY_WORDS)) + 32'(idx_q);

  // Memory port is only driven while a record is being written, zero otherwise.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 4'h0;
    mem_addr_o = 32'd0;
    mem_data_o = 32'd0;
    if (state_q == WRITE) begin
      mem_req_o  = 1'b1;
      mem_we_o   = 4'hF;
      mem_addr_o = mon_addr_i + (word_off << 2);
      mem_data_o = entry_q[idx_q];
    end
  end

  // Next-state logic: FSM, word index and ring head; software reset wins over all.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    head_d  = head_q;
    if (mon_reset_i) begin
      state_d = IDLE;
      idx_d   = '0;
      head_d  = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = WRITE;
            idx_d   = '0;
          end
        end
        WRITE: begin
          if (mem_gnt_i) begin
            if (idx_q == IDX_LAST) begin
              state_d = COMMIT;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          state_d = IDLE;
          head_d  = (head_q == (mon_size_i - 8'd1)) ? 8'd0 : head_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Semaphore updates; a post or wait coinciding with a commit cancels out.
  always_comb begin
    sem_av_d = sem_av_q;
    sem_oc_d = sem_oc_q;
    if (mon_reset_i) begin
      sem_av_d = mon_sem_av_i;
      sem_oc_d = 8'd0;
    end else begin
      if (mon_sem_av_post_i && !commit) begin
        sem_av_d = (sem_av_q == 8'hFF) ? 8'hFF : sem_av_q + 8'd1;
      end else if (commit && !mon_sem_av_post_i) begin
        sem_av_d = sem_av_q - 8'd1;
      end
      if (commit && !mon_sem_oc_wait_i) begin
        sem_oc_d = sem_oc_q + 8'd1;
      end else if (!commit && mon_sem_oc_wait_i && (sem_oc_q != 8'd0)) begin
        sem_oc_d = sem_oc_q - 8'd1;
      end
    end
  end

  // Control and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      head_q   <= 8'd0;
      sem_av_q <= 8'd0;
      sem_oc_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      head_q   <= head_d;
      sem_av_q <= sem_av_d;
      sem_oc_q <= sem_oc_d;
    end
  end

  // Record capture register; contents only matter while in WRITE.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      entry_q <= evt_data_i;
    end
  end

endmodule

// File: tb/tb_mon_queue_ctrl.sv
// Randomized bench for mon_queue_ctrl against a record-level reference model.
module tb_mon_queue_ctrl;
  import DMNIPkg::*;

  localparam int W = MON_ENTRY_WORDS_DEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mon_reset;
  logic [31:0]       mon_addr;
  logic [7:0]        mon_size;
  logic [7:0]        mon_av_init;
  logic              post, wt;
  logic [7:0]        sem_oc;
  logic              active;
  logic              evt_valid, evt_ready;
  logic [W-1:0][31:0] evt_data;
  logic              mem_req, mem_gnt;
  logic [31:0]       mem_addr, mem_data;
  logic [3:0]        mem_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mon_queue_ctrl #(.MON_ENTRY_WORDS(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mon_reset_i(mon_reset),
    .mon_addr_i(mon_addr), .mon_size_i(mon_size), .mon_sem_av_i(mon_av_init),
    .mon_sem_av_post_i(post), .mon_sem_oc_wait_i(wt),
    .mon_sem_oc_o(sem_oc), .mon_active_o(active),
    .evt_valid_i(evt_valid), .evt_ready_o(evt_ready), .evt_data_i(evt_data),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_we_o(mem_we)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a record in flight is a list of word indices still to be
  // written; the slot it occupies is m_head until the commit cycle.
  bit          mon_en = 1'b0;
  bit          m_busy, m_in_commit, m_commit, m_exp_req, m_exp_ready;
  logic [7:0]  m_av, m_oc, m_head;
  logic [31:0] m_rec [W];
  logic [31:0] m_ea;
  int          q[$];
  int          n_commits = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      m_exp_req   = m_busy && (q.size() != 0);
      m_exp_ready = !m_busy && (m_av != 8'd0) && (mon_size != 8'd0) && !mon_reset;
      chk("evt_ready", 32'(evt_ready), 32'(m_exp_ready));
      chk("active", 32'(active), 32'(m_busy));
      chk("sem_oc", 32'(sem_oc), 32'(m_oc));
      chk("mem_req", 32'(mem_req), 32'(m_exp_req));
      chk("mem_we", 32'(mem_we), m_exp_req ? 32'hF : 32'h0);
      if (m_exp_req) begin
        m_ea = mon_addr + ((32'(m_head) * W + 32'(q[0])) * 4);
        chk("mem_addr", mem_addr, m_ea);
        chk("mem_data", mem_data, m_rec[q[0]]);
      end
      m_commit    = m_in_commit;
      m_in_commit = 1'b0;
      if (mon_reset) begin
        m_av   = mon_av_init;
        m_oc   = 8'd0;
        m_head = 8'd0;
        m_busy = 1'b0;
        q.delete();
      end else begin
        if (m_exp_req && mem_gnt) begin
          void'(q.pop_front());
          if (q.size() == 0) m_in_commit = 1'b1;
        end
        if (post && !m_commit) m_av = (m_av == 8'hFF) ? 8'hFF : m_av + 8'd1;
        else if (m_commit && !post) m_av = m_av - 8'd1;
        if (m_commit && !wt) m_oc = m_oc + 8'd1;
        else if (!m_commit && wt && m_oc != 8'd0) m_oc = m_oc - 8'd1;
        if (m_commit) begin
          n_commits++;
          m_head = (m_head == 8'(mon_size - 8'd1)) ? 8'd0 : m_head + 8'd1;
          m_busy = 1'b0;
        end
        if (evt_valid && m_exp_ready) begin
          m_busy = 1'b1;
          for (int i = 0; i < W; i++) begin
            m_rec[i] = evt_data[i];
            q.push_back(i);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_reset(input logic [31:0] a, input logic [7:0] s, input logic [7:0] av);
    mon_reset   = 1'b1;
    mon_addr    = a;
    mon_size    = s;
    mon_av_init = av;
  endtask

  initial begin
    rst_n = 1'b0; mon_reset = 1'b0; mon_addr = 32'd0; mon_size = 8'd0;
    mon_av_init = 8'd0; post = 1'b0; wt = 1'b0; evt_valid = 1'b0;
    mem_gnt = 1'b0; evt_data = '0;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_evt_ready", 32'(evt_ready), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_sem_oc", 32'(sem_oc), 32'd0);
    m_av = 8'd0; m_oc = 8'd0; m_head = 8'd0; m_busy = 1'b0; m_in_commit = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    // Inert until configured: size nonzero but no free slots loaded yet.
    mon_size = 8'd4;
    evt_valid = 1'b1;
    repeat (4) step();

    // Directed: base 0x1000, 4 slots, 4 free, grant tied high, five records
    // with one post after the fourth commit, then wait for backpressure relief.
    mem_gnt = 1'b1;
    cfg_reset(32'h0000_1000, 8'd4, 8'd4);
    step();
    mon_reset = 1'b0;
    for (int i = 0; i < W; i++) evt_data[i] = 32'hA0 + i;
    for (int c = 0; c < 60; c++) begin
      post = (n_commits == 4 && c < 40 && m_av == 8'd0) ? 1'b1 : 1'b0;
      step();
      for (int i = 0; i < W; i++) evt_data[i] = $urandom;
    end
    post = 1'b0;
    evt_valid = 1'b0;
    step(); step();
    chk("dir_commits", 32'(n_commits), 32'd5);
    chk("dir_sem_oc", 32'(sem_oc), 32'd5);

    // Randomized phase: stalls, posts, waits, occasional reconfiguration.
    for (int c = 0; c < 5000; c++) begin
      mon_reset = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        cfg_reset($urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 8)),
                  ($urandom_range(0, 9) == 0) ? 8'hFE : 8'($urandom_range(0, 6)));
      end
      evt_valid = ($urandom_range(0, 9) < 6);
      mem_gnt   = ($urandom_range(0, 9) < 7);
      post      = ($urandom_range(0, 5) == 0);
      wt        = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < W; i++) evt_data[i] = $urandom;
      step();
    end
    mon_reset = 1'b0; evt_valid = 1'b0; post = 1'b0; wt = 1'b0;
    step(); step();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mon_queue_ctrl.md
MON_QUEUE_CTRL -- requirements
Module: mon_queue_ctrl

Interface
REQ-001 SHALL have parameter MON_ENTRY_WORDS, default 4, meaning 32-bit words per monitoring record (range 1..8).
REQ-002 SHALL have ports `clk_i` (in, 1, clock) and `rst_ni` (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-003 SHALL have `mon_reset_i` (in, 1), which reinitialises the queue from the configuration inputs.
REQ-004 SHALL have `mon_addr_i` (in, 32), ring base byte address, word aligned.
REQ-005 SHALL have `mon_size_i` (in, 8), ring capacity in entries.
REQ-006 SHALL have `mon_sem_av_i` (in, 8), initial free-slot count.
REQ-007 SHALL have `mon_sem_av_post_i` (in, 1) and `mon_sem_oc_wait_i` (in, 1), single-cycle software post (free +1) and software consume (occupied −1).
REQ-008 SHALL have `mon_sem_oc_o` (out, 8), occupied count, and `mon_active_o` (out, 1), write in progress.
REQ-009 SHALL have `evt_valid_i` (in, 1), `evt_ready_o` (out, 1) and `evt_data_i` (in, mon_entry_t), the record input.
REQ-010 SHALL have a memory write port:
- `mem_req_o` (out, 1)
- `mem_gnt_i` (in, 1)
- `mem_addr_o` (out, 32)
- `mem_data_o` (out, 32)
- `mem_we_o` (out, 4)

Function
REQ-011 SHALL implement a three-state FSM: IDLE, WRITE, COMMIT.
REQ-012 `evt_ready_o` SHALL be 1 only when all hold:
- state is IDLE
- sem_av != 0
- `mon_size_i` != 0
- `mon_reset_i` = 0
REQ-013 A record SHALL be accepted on `evt_valid_i` & `evt_ready_o`; on acceptance, IDLE→WRITE, `evt_data_i` is captured and the word index is 0.
REQ-014 In WRITE the block SHALL drive:
- `mem_req_o` = 1 and `mem_we_o` = 4'hF
- `mem_data_o` = captured word[idx]
- `mem_addr_o` = `mon_addr_i` + ((head*MON_ENTRY_WORDS + idx) << 2), computed in 32 bits with wrap.
REQ-015 Address and data SHALL remain stable until `mem_gnt_i` is sampled 1; `mem_gnt_i` may be asserted in the same cycle as `mem_req_o`.
REQ-016 On each grant idx SHALL increment; the grant for idx = MON_ENTRY_WORDS−1 SHALL move WRITE→COMMIT.
REQ-017 COMMIT SHALL last exactly one cycle and then return to IDLE, with these updates:
- head = (head == `mon_size_i`−1) ? 0 : head+1
- sem_av −1
- sem_oc +1
REQ-018 `mon_active_o` SHALL be 1 in WRITE and COMMIT and 0 in IDLE.
REQ-019 With `mem_gnt_i` tied to 1 and acceptance in cycle T, the timing SHALL be:
- words issued in cycles T+1..T+MON_ENTRY_WORDS
- COMMIT in cycle T+MON_ENTRY_WORDS+1
- `evt_ready_o` may next be 1 in cycle T+MON_ENTRY_WORDS+2
REQ-020 `mon_sem_av_post_i` SHALL increment sem_av, saturating at 8'hFF.
REQ-021 `mon_sem_oc_wait_i` SHALL decrement sem_oc and SHALL be ignored when sem_oc = 0.
REQ-022 When a post and a COMMIT coincide, sem_av SHALL be unchanged (net 0).
REQ-023 When a wait and a COMMIT coincide, sem_oc SHALL be unchanged (net 0).
REQ-024 `mon_reset_i` SHALL take priority over all other activity: the next state is IDLE, head = 0, sem_oc = 0, sem_av = `mon_sem_av_i` (sampled that cycle), and any pending record is dropped.
REQ-025 On `mon_reset_i` during WRITE, `mem_req_o` SHALL drop in the following cycle and no COMMIT SHALL occur.
REQ-026 When sem_av = 0 the block SHALL apply backpressure (`evt_ready_o` = 0) and SHALL never overwrite an occupied slot or drop a record.
REQ-027 `mon_sem_oc_o` SHALL be the registered sem_oc value.

Reset
REQ-028 On `rst_ni` = 0 the block SHALL enter IDLE with head, idx, sem_av and sem_oc = 0.
REQ-029 On `rst_ni` = 0 the outputs SHALL be:
- `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0
- `evt_ready_o` = 0, `mon_active_o` = 0, `mon_sem_oc_o` = 0
REQ-030 After reset release the block SHALL stay inert (`evt_ready_o` = 0) until `mon_reset_i` loads a nonzero sem_av.

Structure
REQ-031 DMNIPkg SHALL hold:
- constant MON_ENTRY_WORDS_DEF = 4
- typedef mon_entry_t = array of MON_ENTRY_WORDS 32-bit words
- enum mon_queue_state_t {IDLE, WRITE, COMMIT}
REQ-032 The block SHALL be a single module with no sub-modules; semaphore counters are inline registers.

Verification
REQ-033 Basic write, gnt tied 1:
- Stimulus: `mon_reset_i` with addr 0x1000, size 4, av 4; then one record {A0,A1,A2,A3}.
- Response: writes to 0x1000/1004/1008/100C in 4 consecutive cycles, then `mon_sem_oc_o` = 1 and av = 3.
REQ-034 Wrap-around:
- Stimulus: 5 records into size 4 with av = 4, and a post issued after the 4th record.
- Response: the 5th record is written at 0x1000; `mon_sem_oc_o` = 5 (wait not issued).
REQ-035 Full backpressure:
- Stimulus: av reaches 0 while `evt_valid_i` is held high.
- Response: `evt_ready_o` = 0 and no `mem_req_o` until a post; the record is then written at the correct head.
REQ-036 Grant stall:
- Stimulus: `mem_gnt_i` low for 3 cycles on word 1.
- Response: addr/data held stable throughout; total WRITE length = MON_ENTRY_WORDS + 3 cycles.
REQ-037 Simultaneous events:
- Stimulus: post and wait asserted in the COMMIT cycle, with av = 2, oc = 1.
- Response: av = 2, oc = 1 afterwards.
REQ-038 Reset mid-write:
- Stimulus: `mon_reset_i` after word 1 is granted.
- Response: `mem_req_o` = 0 next cycle, no COMMIT, oc = 0, head = 0; the next record is written at the new `mon_addr_i`.
